// File: rtl/rf_debug_access_if.sv
// Host-side command/response channel of the register-file debug initiator.
// The host drives requests and accepts responses; the block is the slave.
interface rf_debug_access_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_cmd;
    logic [4:0]            req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [4:0]            rsp_addr;
    logic                  rsp_last;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
    );
endinterface

// File: rtl/rf_debug_access.sv
// Debug initiator for the CPU register file: halts the core, performs
// read / write / dump-all through the debug port mux, returns beats to the host.
module rf_debug_access #(
    parameter int DATA_WIDTH   = 32,
    parameter int HALT_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_debug_access_if.slave      host,
    output logic                  halt_req,
    input  logic                  halt_ack,
    output logic [4:0]            rf_rd_addr,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data
);
    localparam int TW = (HALT_TIMEOUT > 2) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(HALT_TIMEOUT - 1);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_DUMP  = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_EXEC,
        S_RESP,
        S_RELEASE
    } state_t;

    state_t state, state_next;

    logic [1:0]            cmd;
    logic [4:0]            addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [4:0]            idx;
    logic [TW-1:0]         timer;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [4:0]            rsp_addr_q;
    logic                  rsp_last_q;
    logic                  rsp_err_q;
    logic                  accept;
    logic                  timeout;

    assign host.rsp_data = rsp_data_q;
    assign host.rsp_addr = rsp_addr_q;
    assign host.rsp_last = rsp_last_q;
    assign host.rsp_err  = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        host.req_ready = 1'b0;
        host.rsp_valid = 1'b0;
        halt_req       = 1'b0;
        rf_rd_addr     = '0;
        rf_wr_en       = 1'b0;
        rf_wr_addr     = '0;
        rf_wr_data     = '0;
        accept         = 1'b0;
        timeout        = 1'b0;
        case (state)
            S_IDLE: begin
                // Gated by rst_n so every output reads 0 while reset is held.
                host.req_ready = rst_n;
                accept         = host.req_valid && rst_n;
                if (accept) state_next = (host.req_cmd == CMD_RSVD) ? S_RESP : S_HALT;
            end
            S_HALT: begin
                halt_req = 1'b1;
                if (halt_ack) begin
                    state_next = S_EXEC;
                end else if (timer == TIMER_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_EXEC: begin
                halt_req = 1'b1;
                if (cmd == CMD_DUMP)      rf_rd_addr = idx;
                else if (cmd == CMD_READ) rf_rd_addr = addr;
                if (cmd == CMD_WRITE) begin
                    rf_wr_en   = (addr != 5'd0);
                    rf_wr_addr = addr;
                    rf_wr_data = wdata;
                end
                state_next = S_RESP;
            end
            S_RESP: begin
                halt_req       = (cmd != CMD_RSVD);
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) begin
                    if (cmd == CMD_DUMP && !rsp_err_q && idx != 5'd31) state_next = S_EXEC;
                    else if (cmd == CMD_RSVD)                          state_next = S_IDLE;
                    else                                               state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!halt_ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd        <= '0;
            addr       <= '0;
            wdata      <= '0;
            idx        <= '0;
            timer      <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd   <= host.req_cmd;
                        addr  <= host.req_addr;
                        wdata <= host.req_wdata;
                        idx   <= '0;
                        timer <= '0;
                        if (host.req_cmd == CMD_RSVD) begin
                            rsp_data_q <= '0;
                            rsp_addr_q <= host.req_addr;
                            rsp_last_q <= 1'b1;
                            rsp_err_q  <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (timeout) begin
                        rsp_data_q <= '0;
                        rsp_addr_q <= addr;
                        rsp_last_q <= 1'b1;
                        rsp_err_q  <= 1'b1;
                    end else if (!halt_ack) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_EXEC: begin
                    rsp_data_q <= (cmd == CMD_WRITE) ? wdata : rf_rd_data;
                    rsp_addr_q <= (cmd == CMD_DUMP) ? idx : addr;
                    rsp_last_q <= !(cmd == CMD_DUMP && idx != 5'd31);
                    rsp_err_q  <= 1'b0;
                end
                S_RESP: begin
                    // Dump advances only on an accepted beat, so no index is skipped.
                    if (state_next == S_EXEC) idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_debug_access.sv
// Randomized bench for rf_debug_access: a register-file/core model surrounds the
// DUT, and a reference model predicts every response beat.
module tb_rf_debug_access;
    localparam int DW = 32;
    localparam int HT = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [4:0]    addr;
        logic          last;
        logic          err;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halt_req, halt_ack, rf_wr_en;
    logic [4:0] rf_rd_addr, rf_wr_addr;
    logic [DW-1:0] rf_rd_data, rf_wr_data;

    rf_debug_access_if #(.DATA_WIDTH(DW)) host ();

    rf_debug_access #(.DATA_WIDTH(DW), .HALT_TIMEOUT(HT)) dut (
        .clk(clk), .rst_n(rst_n), .host(host),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: register file and core halt behaviour.
    logic [DW-1:0] rf_mem [32];
    logic env_load = 1'b0;
    logic ack_en = 1'b1;
    logic ack_imm = 1'b0;
    logic ack_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= halt_req;
            if (env_load) for (int i = 0; i < 32; i++) rf_mem[i] <= DW'(i * 17);
            else if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
        end
    end
    assign rf_rd_data = rf_mem[rf_rd_addr];
    assign halt_ack   = ack_en & (ack_imm ? halt_req : ack_q);

    logic [84:0] outs;
    assign outs = {host.req_ready, host.rsp_valid, host.rsp_data, host.rsp_addr, host.rsp_last,
                   host.rsp_err, halt_req, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data};

    int rdy_mode = 0;
    initial begin
        host.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       host.rsp_ready = 1'b1;
                1:       host.rsp_ready = ~host.rsp_ready;
                default: host.rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: accepted beats, valid rise cycles, write pulses, protocol violations.
    beat_t beats[$];
    beat_t held;
    int vrise[$];
    logic [4:0]    wr_a[$];
    logic [DW-1:0] wr_d[$];
    bit hold_pend = 0, prev_v = 0;
    int halt_cyc = 0, stab_err = 0, ready_err = 0;
    always @(negedge clk) begin
        beat_t b;
        b = '{data: host.rsp_data, addr: host.rsp_addr, last: host.rsp_last, err: host.rsp_err};
        if (!rst_n) begin
            hold_pend = 0;
            prev_v    = 0;
        end else begin
            if (host.rsp_valid) begin
                if (!prev_v) vrise.push_back(cyc);
                if (hold_pend && b !== held) stab_err++;
                if (host.rsp_ready) begin
                    beats.push_back(b);
                    hold_pend = 0;
                end else begin
                    hold_pend = 1;
                    held = b;
                end
            end else begin
                if (hold_pend) stab_err++;
                hold_pend = 0;
            end
            prev_v = host.rsp_valid;
            if (rf_wr_en) begin
                wr_a.push_back(rf_wr_addr);
                wr_d.push_back(rf_wr_data);
            end
            if (halt_req) halt_cyc++;
            if (host.req_ready && (halt_req || halt_ack)) ready_err++;
        end
    end

    // Reference model: architectural register contents as the host should see them.
    logic [DW-1:0] ref_rf [32];
    int n_chk = 0, n_pass = 0;

    function automatic beat_t mk(logic [DW-1:0] d, logic [4:0] a, logic l, logic e);
        return '{data: d, addr: a, last: l, err: e};
    endfunction

    function automatic beat_t model_rw(logic [1:0] c, logic [4:0] a, logic [DW-1:0] d);
        if (c == 2'b11) return mk('0, a, 1'b1, 1'b1);
        if (c == 2'b01) begin
            if (a != 0) ref_rf[a] = d;
            return mk(d, a, 1'b1, 1'b0);
        end
        return mk(ref_rf[a], a, 1'b1, 1'b0);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [4:0] a, input logic [DW-1:0] d,
                        output int acc);
        bit ok;
        ok = 0;
        acc = -1;
        host.req_valid = 1'b1;
        host.req_cmd   = c;
        host.req_addr  = a;
        host.req_wdata = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (host.req_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                acc = cyc;
            end
        end
        host.req_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL send: req_ready=0 after 200 cycles, required 1");
        end
    endtask

    task automatic wait_beats(input int target, input int budget);
        for (int i = 0; i < budget && beats.size() < target; i++) @(posedge clk);
        #1;
        if (beats.size() < target) begin
            n_chk++;
            $display("FAIL wait_beats: got %0d beats, required %0d", beats.size(), target);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !host.req_ready; i++) tick(1);
        n_chk++;
        if (host.req_ready !== 1'b1 || halt_req !== 1'b0)
            $display("FAIL idle: req_ready=%b halt_req=%b, required 1/0", host.req_ready, halt_req);
        else n_pass++;
    endtask

    task automatic preload();
        env_load = 1'b1;
        tick(1);
        env_load = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = DW'(i * 17);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        tick(2);
        n_chk++;
        if (outs !== '0) $display("FAIL reset_outs: got %h, required 0", outs); else n_pass++;
        rst_n = 1'b1;
        tick(1);
        n_chk++;
        if (host.req_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", host.req_ready);
        else n_pass++;
    endtask

    task automatic test_read_reset();
        int acc, b0, r0;
        ack_imm = 1'b0; rdy_mode = 0;
        b0 = beats.size(); r0 = ready_err;
        send(2'b00, 5'd5, $urandom, acc);
        wait_beats(b0 + 1, 50);
        n_chk++;
        if (beats[b0] !== mk('0, 5'd5, 1'b1, 1'b0))
            $display("FAIL read_x5: got %h, required %h", beats[b0], mk('0, 5'd5, 1'b1, 1'b0));
        else n_pass++;
        n_chk++;
        if (vrise[$] - acc != 3) $display("FAIL read_lat_delayed_ack: got %0d, required 3", vrise[$] - acc);
        else n_pass++;
        wait_idle();
        n_chk++;
        if (ready_err != r0) $display("FAIL ready_during_halt: got %0d, required %0d", ready_err, r0);
        else n_pass++;
    endtask

    task automatic test_write_read();
        int acc, b0, w0;
        beat_t e;
        ack_imm = 1'b1; rdy_mode = 0;
        b0 = beats.size(); w0 = wr_a.size();
        e = model_rw(2'b01, 5'd7, 32'hDEADBEEF);
        send(2'b01, 5'd7, 32'hDEADBEEF, acc);
        wait_beats(b0 + 1, 50);
        n_chk++;
        if (beats[b0] !== e) $display("FAIL write_x7: got %h, required %h", beats[b0], e); else n_pass++;
        n_chk++;
        if (vrise[$] - acc != 2) $display("FAIL write_lat: got %0d, required 2", vrise[$] - acc); else n_pass++;
        wait_idle();
        n_chk++;
        if (wr_a.size() != w0 + 1 || wr_a[w0] !== 5'd7 || wr_d[w0] !== 32'hDEADBEEF)
            $display("FAIL write_pulse: got %0d pulses, required 1 at x7=deadbeef", wr_a.size() - w0);
        else n_pass++;
        e = model_rw(2'b00, 5'd7, '0);
        send(2'b00, 5'd7, '0, acc);
        wait_beats(b0 + 2, 50);
        n_chk++;
        if (beats[b0+1] !== e) $display("FAIL read_x7: got %h, required %h", beats[b0+1], e); else n_pass++;
        wait_idle();
    endtask

    task automatic test_write_x0();
        int acc, b0, w0;
        beat_t e;
        b0 = beats.size(); w0 = wr_a.size();
        e = model_rw(2'b01, 5'd0, 32'h12345678);
        send(2'b01, 5'd0, 32'h12345678, acc);
        wait_beats(b0 + 1, 50);
        n_chk++;
        if (beats[b0] !== e) $display("FAIL write_x0: got %h, required %h", beats[b0], e); else n_pass++;
        wait_idle();
        n_chk++;
        if (wr_a.size() != w0) $display("FAIL write_x0_wr_en: got %0d pulses, required 0", wr_a.size() - w0);
        else n_pass++;
        e = model_rw(2'b00, 5'd0, '0);
        send(2'b00, 5'd0, '0, acc);
        wait_beats(b0 + 2, 50);
        n_chk++;
        if (beats[b0+1] !== e) $display("FAIL read_x0: got %h, required %h", beats[b0+1], e); else n_pass++;
        wait_idle();
    endtask

    task automatic test_random();
        int acc, b0, w0, r;
        logic [1:0] c;
        logic [4:0] a;
        logic [DW-1:0] d;
        beat_t e;
        for (int it = 0; it < 24; it++) begin
            ack_imm  = 1'($urandom_range(0, 1));
            rdy_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
            r = $urandom_range(0, 9);
            c = (r < 5) ? 2'b00 : (r < 9) ? 2'b01 : 2'b11;
            a = 5'($urandom_range(0, 7));
            d = $urandom;
            b0 = beats.size(); w0 = wr_a.size();
            e = model_rw(c, a, d);
            send(c, a, d, acc);
            wait_beats(b0 + 1, 100);
            n_chk++;
            if (beats[b0] !== e) $display("FAIL random_%0d: got %h, required %h", it, beats[b0], e);
            else n_pass++;
            wait_idle();
            n_chk++;
            if (wr_a.size() - w0 != ((c == 2'b01 && a != 0) ? 1 : 0))
                $display("FAIL random_wr_%0d: got %0d pulses for cmd %0d x%0d", it, wr_a.size() - w0, c, a);
            else n_pass++;
        end
        rdy_mode = 0;
    endtask

    task automatic test_dump();
        int acc, b0, s0;
        ack_imm = 1'b0;
        preload();
        rdy_mode = 1;
        b0 = beats.size(); s0 = stab_err;
        send(2'b10, 5'($urandom_range(0, 31)), $urandom, acc);
        wait_beats(b0 + 32, 400);
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (beats[b0+i] !== mk(ref_rf[i], 5'(i), 1'(i == 31), 1'b0))
                $display("FAIL dump_beat_%0d: got %h, required %h", i, beats[b0+i],
                         mk(ref_rf[i], 5'(i), 1'(i == 31), 1'b0));
            else n_pass++;
        end
        wait_idle();
        rdy_mode = 0;
        n_chk++;
        if (beats.size() != b0 + 32) $display("FAIL dump_count: got %0d, required 32", beats.size() - b0);
        else n_pass++;
        n_chk++;
        if (stab_err != s0) $display("FAIL dump_stable: got %0d violations, required 0", stab_err - s0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int acc, b0, w0, h0;
        ack_en = 1'b0; rdy_mode = 0;
        b0 = beats.size(); w0 = wr_a.size(); h0 = halt_cyc;
        send(2'b01, 5'd3, $urandom, acc);
        wait_beats(b0 + 1, 100);
        n_chk++;
        if (beats[b0] !== mk('0, 5'd3, 1'b1, 1'b1))
            $display("FAIL timeout_rsp: got %h, required %h", beats[b0], mk('0, 5'd3, 1'b1, 1'b1));
        else n_pass++;
        n_chk++;
        if (vrise[$] - acc != HT) $display("FAIL timeout_lat: got %0d, required %0d", vrise[$] - acc, HT);
        else n_pass++;
        wait_idle();
        n_chk++;
        if (halt_cyc - h0 != HT + 1 || wr_a.size() != w0)
            $display("FAIL timeout_halt: got %0d halt cycles %0d writes, required %0d/0",
                     halt_cyc - h0, wr_a.size() - w0, HT + 1);
        else n_pass++;
        ack_en = 1'b1;
    endtask

    task automatic test_reserved();
        int acc, b0, h0;
        logic [4:0] a;
        a = 5'($urandom_range(1, 31));
        b0 = beats.size(); h0 = halt_cyc;
        send(2'b11, a, $urandom, acc);
        wait_beats(b0 + 1, 20);
        n_chk++;
        if (beats[b0] !== mk('0, a, 1'b1, 1'b1))
            $display("FAIL reserved_rsp: got %h, required %h", beats[b0], mk('0, a, 1'b1, 1'b1));
        else n_pass++;
        wait_idle();
        n_chk++;
        if (halt_cyc != h0) $display("FAIL reserved_halt: got %0d halt cycles, required 0", halt_cyc - h0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        int acc, b0;
        bit hit;
        beat_t e;
        logic [DW-1:0] d;
        ack_imm = 1'b1; rdy_mode = 0;
        preload();
        send(2'b10, 5'd0, '0, acc);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (host.rsp_valid && host.rsp_addr == 5'd10) hit = 1;
        end
        n_chk++;
        if (!hit) $display("FAIL mid_dump_beat10: beat 10 not seen, required within 200 cycles");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (outs !== '0) $display("FAIL mid_dump_reset_outs: got %h, required 0", outs); else n_pass++;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        d = $urandom;
        b0 = beats.size();
        e = model_rw(2'b01, 5'd9, d);
        send(2'b01, 5'd9, d, acc);
        wait_beats(b0 + 1, 50);
        n_chk++;
        if (beats[b0] !== e) $display("FAIL post_reset_write: got %h, required %h", beats[b0], e); else n_pass++;
        e = model_rw(2'b00, 5'd9, '0);
        send(2'b00, 5'd9, '0, acc);
        wait_beats(b0 + 2, 50);
        n_chk++;
        if (beats[b0+1] !== e) $display("FAIL post_reset_read: got %h, required %h", beats[b0+1], e);
        else n_pass++;
        wait_idle();
    endtask

    initial begin
        host.req_valid = 1'b0;
        host.req_cmd   = '0;
        host.req_addr  = '0;
        host.req_wdata = '0;
        test_reset();
        test_read_reset();
        test_write_read();
        test_write_x0();
        test_random();
        test_dump();
        test_timeout();
        test_reserved();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
